// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - RISC-V immediate decoder behind a 2-entry valid/ready FIFO
// Optional feature: define IMM_GEN_ZIMM_EN to decode CSR zimm (opcode 1110011, funct3[2]=1) as Z-format.
module imm_gen_pipe #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  out_imm,
   output logic [2:0]       out_fmt,
   output logic [TAG_W-1:0] out_tag
);

   localparam logic [2:0] FMT_NONE = 3'd0;
   localparam logic [2:0] FMT_I    = 3'd1;
   localparam logic [2:0] FMT_S    = 3'd2;
   localparam logic [2:0] FMT_B    = 3'd3;
   localparam logic [2:0] FMT_U    = 3'd4;
   localparam logic [2:0] FMT_J    = 3'd5;
   localparam logic [2:0] FMT_Z    = 3'd6;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } state_t;

   state_t state_q;
   state_t state_d;

   // in_ready is its own flop so it never sees out_ready combinationally
   logic in_ready_q;

   logic accept;
   logic take;

   // Slot 0 is always the oldest entry and drives the outputs directly
   logic [XLEN-1:0]  imm0_q;
   logic [XLEN-1:0]  imm1_q;
   logic [2:0]       fmt0_q;
   logic [2:0]       fmt1_q;
   logic [TAG_W-1:0] tag0_q;
   logic [TAG_W-1:0] tag1_q;

   logic [6:0]       opcode;
   logic [2:0]       dec_fmt;
   logic [31:0]      dec_imm32;
   logic             dec_sext;
   logic [XLEN-1:0]  dec_imm;

   assign opcode = in_instr[6:0];

   // Classify the incoming opcode into an immediate format
   always_comb begin
      dec_fmt = FMT_NONE;
      case (opcode)
         7'b0010011,
         7'b0000011,
         7'b1100111: dec_fmt = FMT_I;
         7'b0011011: begin
            // OP-IMM-32 only exists on RV64
            if (XLEN == 64) begin
               dec_fmt = FMT_I;
            end
         end
         7'b0100011: dec_fmt = FMT_S;
         7'b1100011: dec_fmt = FMT_B;
         7'b0110111,
         7'b0010111: dec_fmt = FMT_U;
         7'b1101111: dec_fmt = FMT_J;
`ifdef IMM_GEN_ZIMM_EN
         7'b1110011: begin
            // Only the immediate CSR forms (funct3 bit 2 set) carry a zimm
            if (in_instr[14]) begin
               dec_fmt = FMT_Z;
            end
         end
`endif
         default: dec_fmt = FMT_NONE;
      endcase
   end

   // Assemble the 32-bit immediate and pick the extension bit for widening
   always_comb begin
      dec_imm32 = 32'd0;
      dec_sext  = in_instr[31];
      case (dec_fmt)
         FMT_I: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
         FMT_S: dec_imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
         FMT_B: dec_imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
         FMT_U: dec_imm32 = {in_instr[31:12], 12'd0};
         FMT_J: dec_imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
         FMT_Z: begin
            // zimm is an unsigned CSR source index, never sign-extended
            dec_imm32 = {27'd0, in_instr[19:15]};
            dec_sext  = 1'b0;
         end
         default: begin
            dec_imm32 = 32'd0;
            dec_sext  = 1'b0;
         end
      endcase
   end

   // Widen to XLEN; U-format is sign-extended too, matching LUI/AUIPC on RV64
   generate
      if (XLEN > 32) begin : g_wide
         assign dec_imm = {{(XLEN-32){dec_sext}}, dec_imm32};
      end else begin : g_narrow
         assign dec_imm = dec_imm32[XLEN-1:0];
      end
   endgenerate

   assign accept = in_valid && in_ready_q;
   assign take   = out_valid && out_ready;

   // State register; reset wins over everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state: flush empties the FIFO and drops any concurrent beat
   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = ST_EMPTY;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  state_d = ST_ONE;
               end
            end
            ST_ONE: begin
               if (accept && !take) begin
                  state_d = ST_FULL;
               end else if (take && !accept) begin
                  state_d = ST_EMPTY;
               end
            end
            ST_FULL: begin
               // in_ready is low here, so only a take can happen
               if (take) begin
                  state_d = ST_ONE;
               end
            end
            default: state_d = ST_EMPTY;
         endcase
      end
   end

   // Registered ready: high whenever the next state still has a free slot
   always_ff @(posedge clk) begin
      if (rst) begin
         in_ready_q <= 1'b1;
      end else begin
         in_ready_q <= (state_d != ST_FULL);
      end
   end

   // Entry storage; slot 1 shifts into slot 0 when the head is consumed
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         imm0_q <= '0;
         fmt0_q <= FMT_NONE;
         tag0_q <= '0;
         imm1_q <= '0;
         fmt1_q <= FMT_NONE;
         tag1_q <= '0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (accept) begin
                  imm0_q <= dec_imm;
                  fmt0_q <= dec_fmt;
                  tag0_q <= in_tag;
               end
            end
            ST_ONE: begin
               if (accept && take) begin
                  imm0_q <= dec_imm;
                  fmt0_q <= dec_fmt;
                  tag0_q <= in_tag;
               end else if (accept) begin
                  imm1_q <= dec_imm;
                  fmt1_q <= dec_fmt;
                  tag1_q <= in_tag;
               end
            end
            ST_FULL: begin
               if (take) begin
                  imm0_q <= imm1_q;
                  fmt0_q <= fmt1_q;
                  tag0_q <= tag1_q;
               end
            end
            default: begin
               imm0_q <= imm0_q;
            end
         endcase
      end
   end

   // Outputs present the head entry; valid whenever anything is buffered
   always_comb begin
      out_valid = (state_q != ST_EMPTY);
      in_ready  = in_ready_q;
      out_imm   = imm0_q;
      out_fmt   = fmt0_q;
      out_tag   = tag0_q;
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - randomized + directed bench for imm_gen_pipe at XLEN 32 and 64
module tb_imm_gen_pipe;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] in_instr;
   logic [3:0]  in_tag;

   logic        rdy32, vld32, rdy64, vld64;
   logic [31:0] imm32;
   logic [63:0] imm64;
   logic [2:0]  fmt32, fmt64;
   logic [3:0]  tag32, tag64;

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .TAG_W(4)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy32), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(vld32), .out_ready(out_ready), .out_imm(imm32), .out_fmt(fmt32), .out_tag(tag32)
   );

   imm_gen_pipe #(.XLEN(64), .TAG_W(4)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(rdy64), .in_instr(in_instr), .in_tag(in_tag),
      .out_valid(vld64), .out_ready(out_ready), .out_imm(imm64), .out_fmt(fmt64), .out_tag(tag64)
   );

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  tag;
   } beat_t;

   beat_t      q[$];
   logic [3:0] obs[$];
   int         n_checks = 0;
   int         n_pass   = 0;

   localparam logic [6:0] OPS [0:10] = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63,
                                         7'h37, 7'h17, 7'h6F, 7'h73, 7'h33};

   // Reference decode by plain arithmetic on the bit fields
   function automatic void ref_dec(input logic [31:0] ins, input int xlen,
                                   output logic [63:0] imm, output logic [2:0] fmt);
      longint     v;
      logic [6:0] op;
      op  = ins[6:0];
      v   = 0;
      fmt = 3'd0;
      if (op == 7'h13 || op == 7'h03 || op == 7'h67 || (op == 7'h1B && xlen == 64)) begin
         fmt = 3'd1;
         v = ins[31:20];
         if (v >= 2048) v = v - 4096;
      end else if (op == 7'h23) begin
         fmt = 3'd2;
         v = ins[31:25] * 64'd32 + ins[11:7];
         if (v >= 2048) v = v - 4096;
      end else if (op == 7'h63) begin
         fmt = 3'd3;
         v = ins[31] * 64'd4096 + ins[7] * 64'd2048 + ins[30:25] * 64'd32 + ins[11:8] * 64'd2;
         if (v >= 4096) v = v - 8192;
      end else if (op == 7'h37 || op == 7'h17) begin
         fmt = 3'd4;
         v = ins[31:12] * 64'd4096;
         if (v >= 64'sd2147483648) v = v - 64'sd4294967296;
      end else if (op == 7'h6F) begin
         fmt = 3'd5;
         v = ins[31] * 64'd1048576 + ins[19:12] * 64'd4096 + ins[20] * 64'd2048 + ins[30:21] * 64'd2;
         if (v >= 1048576) v = v - 2097152;
      end
`ifdef IMM_GEN_ZIMM_EN
      else if (op == 7'h73 && ins[14]) begin
         fmt = 3'd6;
         v = ins[19:15];
      end
`endif
      imm = v;
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      n_checks++;
      if (act === want) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, want);
   endtask

   // One clock: compare both DUTs with the model at negedge, then advance the model at posedge
   task automatic step(output bit acc);
      logic [63:0] e;
      logic [2:0]  f;
      bit          tk;
      @(negedge clk);
      chk("valid32", vld32, q.size() != 0);
      chk("ready32", rdy32, q.size() < 2);
      chk("valid64", vld64, q.size() != 0);
      chk("ready64", rdy64, q.size() < 2);
      if (q.size() != 0) begin
         ref_dec(q[0].instr, 32, e, f);
         chk("imm32", imm32, {32'd0, e[31:0]});
         chk("fmt32", fmt32, f);
         chk("tag32", tag32, q[0].tag);
         ref_dec(q[0].instr, 64, e, f);
         chk("imm64", imm64, e);
         chk("fmt64", fmt64, f);
         chk("tag64", tag64, q[0].tag);
      end
      acc = !rst && !flush && in_valid && (q.size() < 2);
      tk  = !rst && !flush && out_ready && (q.size() != 0);
      if (!rst && !flush && vld32 && out_ready) obs.push_back(tag32);
      @(posedge clk);
      if (rst || flush) q.delete();
      else begin
         if (tk) void'(q.pop_front());
         if (acc) q.push_back('{in_instr, in_tag});
      end
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] ins, input logic [3:0] t);
      in_valid = v;
      in_instr = ins;
      in_tag   = t;
   endtask

   initial begin
      logic [63:0] e;
      logic [2:0]  f;
      bit          acc;
      int          tries;
      logic [31:0] r;

      rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
      drive(1'b0, 32'd0, 4'd0);
      step(acc);
      step(acc);
      chk("rst_vld32", vld32, 0); chk("rst_rdy32", rdy32, 1);
      chk("rst_imm32", imm32, 0); chk("rst_fmt32", fmt32, 0); chk("rst_tag32", tag32, 0);
      chk("rst_vld64", vld64, 0); chk("rst_rdy64", rdy64, 1);
      chk("rst_imm64", imm64, 0); chk("rst_fmt64", fmt64, 0); chk("rst_tag64", tag64, 0);
      rst = 1'b0;

      ref_dec(32'hFFF00093, 32, e, f);
      chk("ref_i_imm", e[31:0], 32'hFFFFFFFF); chk("ref_i_fmt", f, 1);
      ref_dec(32'hFE112E23, 32, e, f);
      chk("ref_s_imm", e[31:0], 32'hFFFFFFFC); chk("ref_s_fmt", f, 2);
      ref_dec(32'h800002B7, 64, e, f);
      chk("ref_u_imm", e, 64'hFFFFFFFF80000000); chk("ref_u_fmt", f, 4);

      out_ready = 1'b1;
      drive(1'b1, 32'hFFF00093, 4'd5); step(acc);
      chk("lat_vld", vld32, 1); chk("i_imm32", imm32, 32'hFFFFFFFF);
      chk("i_imm64", imm64, 64'hFFFFFFFFFFFFFFFF); chk("i_fmt", fmt32, 1); chk("i_tag", tag32, 5);
      drive(1'b1, 32'hFE112E23, 4'd6); step(acc);
      chk("s_imm32", imm32, 32'hFFFFFFFC); chk("s_fmt", fmt32, 2); chk("s_tag", tag32, 6);
      drive(1'b1, 32'h800002B7, 4'd7); step(acc);
      chk("u_imm64", imm64, 64'hFFFFFFFF80000000); chk("u_fmt64", fmt64, 4);
      chk("u_imm32", imm32, 32'h80000000);
      drive(1'b1, 32'h300FD073, 4'd8); step(acc);
`ifdef IMM_GEN_ZIMM_EN
      chk("z_fmt", fmt32, 6); chk("z_imm", imm32, 31);
`else
      chk("z_fmt", fmt32, 0); chk("z_imm", imm32, 0);
`endif
      chk("z_tag", tag32, 8);
      drive(1'b1, 32'hFFF0001B, 4'd9); step(acc);
      chk("w_fmt32", fmt32, 0); chk("w_imm32", imm32, 0);
      chk("w_fmt64", fmt64, 1); chk("w_imm64", imm64, 64'hFFFFFFFFFFFFFFFF);
      drive(1'b0, 32'd0, 4'd0); step(acc);

      // Backpressure: three beats, the third held by the source
      obs.delete();
      out_ready = 1'b0;
      drive(1'b1, 32'h00100093, 4'd1); step(acc);
      drive(1'b1, 32'h00200093, 4'd2); step(acc);
      chk("bp_rdy32", rdy32, 0); chk("bp_rdy64", rdy64, 0);
      drive(1'b1, 32'h00300093, 4'd3); step(acc);
      chk("bp_held", acc, 0);
      out_ready = 1'b1;
      tries = 0;
      do begin
         step(acc);
         tries++;
      end while (!acc && tries < 10);
      chk("bp_accept3", acc, 1);
      drive(1'b0, 32'd0, 4'd0);
      repeat (4) step(acc);
      chk("bp_count", obs.size(), 3);
      for (int i = 0; i < 3; i++) chk("bp_order", (obs.size() > i) ? obs[i] : 4'hx, i + 1);

      // Flush while FULL with a concurrent input beat
      obs.delete();
      out_ready = 1'b0;
      drive(1'b1, 32'h00400093, 4'd4); step(acc);
      drive(1'b1, 32'h00500093, 4'd5); step(acc);
      flush = 1'b1;
      drive(1'b1, 32'h00E00093, 4'd14); step(acc);
      flush = 1'b0;
      drive(1'b0, 32'd0, 4'd0);
      chk("fl_vld32", vld32, 0); chk("fl_rdy32", rdy32, 1);
      chk("fl_vld64", vld64, 0); chk("fl_rdy64", rdy64, 1);
      out_ready = 1'b1;
      repeat (3) step(acc);
      chk("fl_dropped", obs.size(), 0);

      // Reset mid-stream while FULL
      out_ready = 1'b0;
      drive(1'b1, 32'h00600093, 4'd6); step(acc);
      drive(1'b1, 32'h00700093, 4'd7); step(acc);
      rst = 1'b1;
      drive(1'b1, 32'h00F00093, 4'd15); step(acc);
      rst = 1'b0;
      chk("mr_vld", vld32, 0); chk("mr_rdy", rdy32, 1); chk("mr_imm", imm32, 0);
      chk("mr_fmt", fmt32, 0); chk("mr_tag", tag32, 0); chk("mr_imm64", imm64, 0);
      out_ready = 1'b1;
      drive(1'b1, 32'hFE112E23, 4'd10); step(acc);
      chk("mr_lat_vld", vld32, 1); chk("mr_lat_tag", tag32, 10); chk("mr_lat_imm", imm32, 32'hFFFFFFFC);
      drive(1'b0, 32'd0, 4'd0); step(acc);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         rst       = ($urandom_range(0, 199) == 0);
         flush     = ($urandom_range(0, 39) == 0);
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 6);
         r         = $urandom;
         if ($urandom_range(0, 9) < 8) in_instr = {r[31:7], OPS[$urandom_range(0, 10)]};
         else in_instr = r;
         in_tag = 4'($urandom);
         step(acc);
      end
      rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      repeat (3) step(acc);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
IMM_GEN_PIPE -- requirements
Module: imm_gen_pipe

Interface
REQ-001 Parameter XLEN, default 32, immediate output width; legal values 32 and 64.
REQ-002 Parameter TAG_W, default 4, width of the sideband tag carried with each instruction.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 flush  input  1  discards every buffered entry.
REQ-006 in_valid  input  1  in_instr/in_tag are valid.
REQ-007 in_ready  output  1  block can accept a beat this cycle.
REQ-008 in_instr  input  32  full instruction word.
REQ-009 in_tag  input  TAG_W  opaque sideband, returned unchanged with its result.
REQ-010 out_valid  output  1  out_imm/out_fmt/out_tag are valid.
REQ-011 out_ready  input  1  consumer accepts the beat this cycle.
REQ-012 out_imm  output  XLEN  sign-extended immediate.
REQ-013 out_fmt  output  3  format code: 0 NONE, 1 I, 2 S, 3 B, 4 U, 5 J, 6 Z; 7 is reserved.
REQ-014 out_tag  output  TAG_W  tag of the current output beat.

Function
REQ-015 The block SHALL contain a 2-entry FIFO with states EMPTY, ONE and FULL; each entry holds the decoded imm, fmt and tag.
REQ-016 in_ready SHALL be a registered signal that is 1 in EMPTY and ONE, and 0 in FULL; it SHALL NOT depend combinationally on out_ready.
REQ-017 An input beat is accepted when in_valid && in_ready; an output beat is taken when out_valid && out_ready.
REQ-018 Latency SHALL be 1 cycle: a beat accepted in cycle N while EMPTY SHALL appear at the output in cycle N+1.
REQ-019 out_valid SHALL be 1 exactly in ONE and FULL; the outputs SHALL present the oldest entry.
REQ-020 State transitions:
- accept-only increments the count.
- take-only decrements it.
- accept and take in the same cycle holds the count and preserves FIFO order.
REQ-021 Output values SHALL be stable while out_valid && !out_ready.
REQ-022 Decoding SHALL use opcode = in_instr[6:0]:
- I-format for 0010011, 0000011 and 1100111, and for 0011011 when XLEN=64 only.
- S-format for 0100011.
- B-format for 1100011.
- U-format for 0110111 and 0010111.
- J-format for 1101111.
- Any other opcode gives NONE.
REQ-023 Bit assembly SHALL follow RV32I:
- I: instr[31:20].
- S: {instr[31:25], instr[11:7]}.
- B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}.
- U: {instr[31:12], 12'b0}.
- J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-024 All formats SHALL be sign-extended from instr[31] to XLEN; this includes U-format when XLEN=64.
REQ-025 The NONE format SHALL output imm 0 and still pass through as a normal beat with its tag.
REQ-026 When flush=1, the next state SHALL be EMPTY and any concurrent input beat SHALL be dropped; flush has priority over accept and take.
REQ-027 During flush, in_ready SHALL read 1 in the following cycle.

Reset
REQ-028 When rst=1 at a clock edge, the state SHALL become EMPTY, with out_valid=0, in_ready=1, out_imm=0, out_fmt=0 and out_tag=0.
REQ-029 Reset SHALL abandon in-flight beats without producing output, and SHALL take priority over flush and all handshakes.

Configuration
REQ-030 Macro IMM_GEN_ZIMM_EN: when defined, opcode 1110011 with in_instr[14]=1 SHALL decode as Z-format with imm = zero-extended in_instr[19:15].
REQ-031 When IMM_GEN_ZIMM_EN is undefined, that opcode SHALL decode as NONE with imm 0; no other behaviour changes.

Verification
REQ-032 XLEN=32, EMPTY, in_instr=0xFFF00093 accepted in cycle N -> cycle N+1: out_valid=1, out_imm=0xFFFFFFFF, out_fmt=1, tag echoed.
REQ-033 in_instr=0xFE112E23 (sw) -> out_imm=0xFFFFFFFC, out_fmt=2; in_instr=0x800002B7 at XLEN=64 -> out_imm=0xFFFFFFFF80000000, out_fmt=4.
REQ-034 Backpressure: out_ready=0 with 3 back-to-back beats, tags 1,2,3:
- in_ready=0 after 2 beats are accepted; beat 3 is held by the source.
- Then out_ready=1: outputs leave in order 1,2,3 with no loss or duplication.
REQ-035 Flush: state FULL, flush=1 together with in_valid=1 -> next cycle out_valid=0 and in_ready=1; the dropped beat never appears.
REQ-036 in_instr=0x300FD073 (csrrwi) -> with IMM_GEN_ZIMM_EN: out_fmt=6, out_imm=31; without it: out_fmt=0, out_imm=0.
REQ-037 Assert rst mid-stream while in FULL -> next cycle all outputs are 0 and in_ready=1; the first beat after reset comes out with 1-cycle latency.
